btn_conditioner: RTL and testbench

//  Turns a raw push-button pin into clean one-cycle events for downstream control counters.

---
 rtl/btn_conditioner.sv | 171 +++++++++++++++++
 tb/tb_btn_conditioner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
//   Converts a raw, bouncing push-button pin into clean single-cycle events.
//   Processing chain: 2-FF synchronizer -> tick-sampled debouncer -> press FSM.
//
// Ports
//   CLK      in   system clock (single clock domain)
//   RST      in   synchronous reset, active-high
//   BTNIN    in   raw button level, active-high, asynchronous to CLK
//   BTNOUT   out  one-cycle pulse per press, plus auto-repeat pulses in LONG
//   BTNREL   out  one-cycle pulse per debounced release
//   BTNLONG  out  one-cycle pulse when the hold reaches the long-press length
//   BTNHOLD  out  debounced button level
// ---------------------------------------------------------------------------
module btn_conditioner #(
  parameter int SMPL_DIV    = 500000,
  parameter int DB_CNT      = 4,
  parameter int LONG_SMPL   = 100,
  parameter int REPEAT_EN   = 1,
  parameter int REPEAT_SMPL = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTNIN,
  output logic BTNOUT,
  output logic BTNREL,
  output logic BTNLONG,
  output logic BTNHOLD
);

  localparam int CW = $clog2(SMPL_DIV);
  localparam int AW = $clog2(DB_CNT + 1);
  localparam int HW = $clog2(LONG_SMPL + 1);
  localparam int RW = $clog2(REPEAT_SMPL + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(SMPL_DIV - 1);
  localparam logic [AW-1:0] AGREE_LAST = AW'(DB_CNT - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_SMPL);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_SMPL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  logic          sync1_q, sync2_q;
  logic [CW-1:0] divCnt_q, divCnt_d;
  logic          tick;
  logic          level_q, level_d;
  logic [AW-1:0] agree_q, agree_d;

  state_t        state_q;
  logic [HW-1:0] hold_q;
  logic [RW-1:0] rpt_q;
  logic          btnOut_q, btnRel_q, btnLong_q;

  assign tick = (divCnt_q == CNT_LAST);

  // Sample divider: free-running counter wrapping at SMPL_DIV-1; the tick
  // is the single cycle on which the counter sits at its last value.
  always_comb begin
    divCnt_d = tick ? '0 : divCnt_q + CW'(1);
  end

  // Debouncer: only a run of DB_CNT consecutive disagreeing samples flips
  // the level; a single agreeing sample throws the partial run away.
  always_comb begin
    level_d = level_q;
    agree_d = agree_q;
    if (tick) begin
      if (sync2_q != level_q) begin
        if (agree_q == AGREE_LAST) begin
          level_d = sync2_q;
          agree_d = '0;
        end else begin
          agree_d = agree_q + AW'(1);
        end
      end else begin
        agree_d = '0;
      end
    end
  end

  // Synchronizer, divider and debouncer state. The button being held
  // through reset shows up as a fresh press since level restarts at 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      divCnt_q <= '0;
      level_q  <= 1'b0;
      agree_q  <= '0;
    end else begin
      sync1_q  <= BTNIN;
      sync2_q  <= sync1_q;
      divCnt_q <= divCnt_d;
      level_q  <= level_d;
      agree_q  <= agree_d;
    end
  end

  // Press FSM with registered pulse outputs. A falling level is checked
  // before the hold/repeat terminal counts so a release always wins a tie.
  // The terminal counts are tested on the registered counters, so the
  // transition lands one cycle after the counting tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      rpt_q     <= '0;
      btnOut_q  <= 1'b0;
      btnRel_q  <= 1'b0;
      btnLong_q <= 1'b0;
    end else begin
      btnOut_q  <= 1'b0;
      btnRel_q  <= 1'b0;
      btnLong_q <= 1'b0;
      case (state_q)
        IDLE: begin
          hold_q <= '0;
          rpt_q  <= '0;
          if (level_q) begin
            state_q  <= PRESS;
            btnOut_q <= 1'b1;
          end
        end
        PRESS: begin
          if (!level_q) begin
            state_q  <= IDLE;
            btnRel_q <= 1'b1;
            hold_q   <= '0;
            rpt_q    <= '0;
          end else if (hold_q == HOLD_LAST) begin
            state_q   <= LONG;
            btnLong_q <= 1'b1;
            rpt_q     <= '0;
          end else if (tick) begin
            hold_q <= hold_q + HW'(1);
          end
        end
        LONG: begin
          if (!level_q) begin
            state_q  <= IDLE;
            btnRel_q <= 1'b1;
            hold_q   <= '0;
            rpt_q    <= '0;
          end else if (rpt_q == RPT_LAST) begin
            rpt_q <= '0;
            if (REPEAT_EN != 0) begin
              btnOut_q <= 1'b1;
            end
          end else if (tick) begin
            rpt_q <= rpt_q + RW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          hold_q  <= '0;
          rpt_q   <= '0;
        end
      endcase
    end
  end

  assign BTNOUT  = btnOut_q;
  assign BTNREL  = btnRel_q;
  assign BTNLONG = btnLong_q;
  assign BTNHOLD = level_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_conditioner
//   Scoreboard bench for btn_conditioner. Two instances share the button and
//   reset: inst 0 with auto-repeat enabled, inst 1 with it disabled. Stimulus
//   pushes the expected pulse events (kind plus cycle window, either absolute
//   or as a gap from the previous event); a negedge monitor pops one entry
//   for every pulse the DUT presents.
// ---------------------------------------------------------------------------
module tb_btn_conditioner;

  localparam int K_OUT  = 0;
  localparam int K_REL  = 1;
  localparam int K_LONG = 2;

  typedef struct {
    int kind;
    int lo;
    int hi;
    bit rel;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  logic BTNIN;
  logic out0, rel0, long0, hold0;
  logic out1, rel1, long1, hold1;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[2][$];
  int   lastEvt[2];

  btn_conditioner #(
    .SMPL_DIV(4), .DB_CNT(3), .LONG_SMPL(8), .REPEAT_EN(1), .REPEAT_SMPL(2)
  ) dut0 (
    .CLK(CLK), .RST(RST), .BTNIN(BTNIN),
    .BTNOUT(out0), .BTNREL(rel0), .BTNLONG(long0), .BTNHOLD(hold0)
  );

  btn_conditioner #(
    .SMPL_DIV(4), .DB_CNT(3), .LONG_SMPL(8), .REPEAT_EN(0), .REPEAT_SMPL(2)
  ) dut1 (
    .CLK(CLK), .RST(RST), .BTNIN(BTNIN),
    .BTNOUT(out1), .BTNREL(rel1), .BTNLONG(long1), .BTNHOLD(hold1)
  );

  // Clock and cycle counter (number of rising edges seen so far)
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic string kindName(input int k);
    case (k)
      K_OUT:   kindName = "BTNOUT";
      K_REL:   kindName = "BTNREL";
      K_LONG:  kindName = "BTNLONG";
      default: kindName = "?";
    endcase
  endfunction

  task automatic compare(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic expectEvt(input int inst, input int kind, input int lo, input int hi, input bit rel);
    exp_t e;
    e.kind = kind;
    e.lo   = lo;
    e.hi   = hi;
    e.rel  = rel;
    q[inst].push_back(e);
  endtask

  task automatic expectBoth(input int kind, input int lo, input int hi);
    expectEvt(0, kind, lo, hi, 1'b0);
    expectEvt(1, kind, lo, hi, 1'b0);
  endtask

  // Drive the button at a negedge, then hold it for the given cycles
  task automatic applyStimulus(input logic lvl, input int cycles);
    BTNIN = lvl;
    repeat (cycles) @(negedge CLK);
  endtask

  // Pop and compare one scoreboard entry for any pulse presented by an instance
  task automatic checkOutput(input int inst, input logic o, input logic r, input logic l);
    exp_t e;
    int   kind;
    int   refCyc;
    if (o || r || l) begin
      kind = o ? K_OUT : (r ? K_REL : K_LONG);
      compare($sformatf("inst%0d single pulse", inst), int'(o) + int'(r) + int'(l), 1, 1);
      if (q[inst].size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL inst%0d unexpected %s: got pulse at cycle %0d, expected none",
                 inst, kindName(kind), cyc);
      end else begin
        e = q[inst].pop_front();
        compare($sformatf("inst%0d kind(%s)", inst, kindName(kind)), kind, e.kind, e.kind);
        refCyc = e.rel ? lastEvt[inst] : 0;
        compare($sformatf("inst%0d %s timing", inst, kindName(e.kind)), cyc - refCyc, e.lo, e.hi);
      end
      lastEvt[inst] = cyc;
    end
  endtask

  // Monitor process, decoupled from stimulus
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      checkOutput(0, out0, rel0, long0);
      checkOutput(1, out1, rel1, long1);
    end
  end

  initial begin
    int c;
    exp_t e;
    lastEvt[0] = 0;
    lastEvt[1] = 0;
    RST   = 1'b1;
    BTNIN = 1'b1;

    // Reset with the button held: everything quiet, then a fresh press
    repeat (3) begin
      @(negedge CLK);
      compare("reset outputs inst0", int'({out0, rel0, long0, hold0}), 0, 0);
      compare("reset outputs inst1", int'({out1, rel1, long1, hold1}), 0, 0);
    end
    RST = 1'b0;
    c = cyc;
    expectBoth(K_OUT, c + 10, c + 15);
    applyStimulus(1'b1, 20);
    compare("held-through-reset BTNHOLD inst0", int'(hold0), 1, 1);
    c = cyc;
    expectBoth(K_REL, c + 10, c + 15);
    applyStimulus(1'b0, 30);
    compare("post-reset release BTNHOLD inst0", int'(hold0), 0, 0);

    // Glitch rejection: short pulse, then a 3-on/3-off bounce
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 20);
    compare("short glitch BTNHOLD inst0", int'(hold0), 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 3);
      applyStimulus(1'b0, 3);
    end
    applyStimulus(1'b0, 30);
    compare("bounce BTNHOLD inst0", int'(hold0), 0, 0);
    compare("bounce BTNHOLD inst1", int'(hold1), 0, 0);

    // Clean press shorter than the long-press threshold, then release
    c = cyc;
    expectBoth(K_OUT, c + 10, c + 15);
    applyStimulus(1'b1, 28);
    compare("clean press BTNHOLD inst0", int'(hold0), 1, 1);
    compare("clean press BTNHOLD inst1", int'(hold1), 1, 1);
    c = cyc;
    expectBoth(K_REL, c + 10, c + 15);
    applyStimulus(1'b0, 30);
    compare("clean release BTNHOLD inst0", int'(hold0), 0, 0);

    // Long press held 100 cycles: long 32 after the press pulse, repeats
    // every 8 on inst0, release 4 after the last repeat (68 after long on inst1)
    c = cyc;
    expectBoth(K_OUT, c + 10, c + 15);
    expectEvt(0, K_LONG, 32, 32, 1'b1);
    for (int i = 0; i < 8; i++) expectEvt(0, K_OUT, 8, 8, 1'b1);
    expectEvt(0, K_REL, 4, 4, 1'b1);
    expectEvt(1, K_LONG, 32, 32, 1'b1);
    expectEvt(1, K_REL, 68, 68, 1'b1);
    applyStimulus(1'b1, 100);
    compare("long hold BTNHOLD inst0", int'(hold0), 1, 1);
    applyStimulus(1'b0, 30);
    compare("long release BTNHOLD inst0", int'(hold0), 0, 0);
    compare("long release BTNHOLD inst1", int'(hold1), 0, 0);

    // Drain: anything still queued was never produced
    for (int i = 0; i < 60 && (q[0].size() != 0 || q[1].size() != 0); i++) @(negedge CLK);
    for (int inst = 0; inst < 2; inst++) begin
      while (q[inst].size() != 0) begin
        e = q[inst].pop_front();
        total++;
        bad++;
        $display("[TB] FAIL inst%0d missing %s: got none, expected one", inst, kindName(e.kind));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
